clb_cfg_loader: RTL and testbench

Configuration controller for a row of CLB tiles. It receives framed configuration words on a valid/ready stream and stages them in shadow registers. After a checksum check it commits all staged words to the CLBs' 13-bit configuration buses in a single cycle, holding the fabric in reset across the update. It sits between the wrapper's configuration port and the `confi` inputs of the CLB instances.

---
 rtl/clb_cfg_pkg.sv | 41 ++++
 rtl/clb_cfg_loader.sv | 181 ++++++++++++++++++
 tb/tb_clb_cfg_loader.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clb_cfg_pkg.sv
// clb_cfg_pkg: shared constants and types for the CLB configuration loader.
//   - CFG_W and the bit offsets of the fields inside one CLB config word
//   - HDR_MAGIC: value of the header magic nibble
//   - state_t: loader FSM states
//   - ERR_*: values reported on err_code_o
//   - hdr_start / hdr_len: header field decoders, widened to 5 bits for range math
package clb_cfg_pkg;

  localparam int CFG_W     = 13;
  localparam int MODE_LSB  = 0;
  localparam int SELA_LSB  = 2;
  localparam int SELB_LSB  = 5;
  localparam int ROUTE_LSB = 8;
  localparam int FFEN_BIT  = 12;

  localparam logic [3:0] HDR_MAGIC = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_MAGIC = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_CSUM  = 2'b11;

  // First CLB index addressed by a header.
  function automatic logic [4:0] hdr_start(input logic [15:0] hdr);
    return {1'b0, hdr[11:8]};
  endfunction

  // Number of data words in the frame (1..16).
  function automatic logic [4:0] hdr_len(input logic [15:0] hdr);
    return {1'b0, hdr[7:4]} + 5'd1;
  endfunction

endpackage

// File: rtl/clb_cfg_loader.sv
// clb_cfg_loader: receives framed configuration words (header, N data words,
// XOR checksum) on a valid/ready stream, stages them in a shadow copy and, once
// the checksum matches, commits the whole shadow to the active CLB configuration
// in a single cycle while holding the fabric in reset.
//
// Ports
//   clk_i         system clock, rising edge
//   rst_i         asynchronous active-high reset
//   word_i        configuration stream word
//   valid_i       word_i valid
//   ready_o       loader accepts word_i (transfer on valid_i && ready_o)
//   cfg_o         active configuration, CLB k on cfg_o[13k+12:13k]
//   fabric_rst_o  active-high reset request to the CLB fabric
//   busy_o        frame in progress (FSM not idle)
//   done_o        one-cycle pulse after a successful commit
//   err_o         sticky error flag, cleared by the next accepted header
//   err_code_o    00 none, 01 bad magic, 10 range, 11 checksum
module clb_cfg_loader
  import clb_cfg_pkg::*;
#(
  parameter int NUM_CLB = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [15:0]              word_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [NUM_CLB*CFG_W-1:0] cfg_o,
  output logic                     fabric_rst_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [1:0]               err_code_o
);

  localparam int         ARR_W     = NUM_CLB * CFG_W;
  localparam logic [4:0] NUM_CLB_W = 5'(NUM_CLB);

  state_t            state_r;
  logic [4:0]        idx_r;
  logic [4:0]        rem_r;
  logic [15:0]       xor_r;
  logic [ARR_W-1:0]  shadow_r;
  logic [ARR_W-1:0]  active_r;
  logic              ready_r;
  logic              busy_r;
  logic              done_r;
  logic              fab_rst_r;
  logic              err_r;
  logic [1:0]        err_code_r;

  logic              accept_s;
  logic [4:0]        hdr_start_s;
  logic [4:0]        hdr_len_s;
  logic [4:0]        hdr_end_s;

  // ready is forced low while reset is held so no word can slip in during reset.
  assign ready_o      = ready_r & ~rst_i;
  assign accept_s     = valid_i & ready_o;
  assign hdr_start_s  = hdr_start(word_i);
  assign hdr_len_s    = hdr_len(word_i);
  // S (max 15) + N (max 16) fits in 5 bits, so the range compare cannot wrap.
  assign hdr_end_s    = hdr_start_s + hdr_len_s;

  assign cfg_o        = active_r;
  assign fabric_rst_o = fab_rst_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;
  assign err_o        = err_r;
  assign err_code_o   = err_code_r;

  // Loader FSM: frame parsing, shadow staging, commit and all registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      idx_r      <= 5'd0;
      rem_r      <= 5'd0;
      xor_r      <= 16'h0000;
      shadow_r   <= '0;
      active_r   <= '0;
      ready_r    <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      fab_rst_r  <= 1'b1;
      err_r      <= 1'b0;
      err_code_r <= ERR_NONE;
    end else begin
      done_r <= 1'b0;
      // The fabric reset drops once the done cycle has passed; before the first
      // commit done_r never rises, so it stays asserted from reset.
      if (done_r) begin
        fab_rst_r <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            xor_r      <= word_i;
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
            if (word_i[15:12] != HDR_MAGIC) begin
              err_r      <= 1'b1;
              err_code_r <= ERR_MAGIC;
            end else if (hdr_end_s > NUM_CLB_W) begin
              // Swallow the rest of the frame: N data words plus the checksum.
              err_r      <= 1'b1;
              err_code_r <= ERR_RANGE;
              rem_r      <= hdr_len_s + 5'd1;
              busy_r     <= 1'b1;
              state_r    <= ST_DRAIN;
            end else begin
              idx_r      <= hdr_start_s;
              rem_r      <= hdr_len_s;
              busy_r     <= 1'b1;
              state_r    <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          if (accept_s) begin
            for (int k = 0; k < NUM_CLB; k++) begin
              if (idx_r == 5'(k)) begin
                shadow_r[k*CFG_W +: CFG_W] <= word_i[CFG_W-1:0];
              end
            end
            xor_r <= xor_r ^ word_i;
            idx_r <= idx_r + 5'd1;
            rem_r <= rem_r - 5'd1;
            if (rem_r == 5'd1) begin
              state_r <= ST_CHECK;
            end
          end
        end

        ST_CHECK: begin
          if (accept_s) begin
            if (word_i == xor_r) begin
              ready_r   <= 1'b0;
              fab_rst_r <= 1'b1;
              state_r   <= ST_COMMIT;
            end else begin
              // Discard the staged words so shadow mirrors active again in IDLE.
              shadow_r   <= active_r;
              err_r      <= 1'b1;
              err_code_r <= ERR_CSUM;
              busy_r     <= 1'b0;
              state_r    <= ST_IDLE;
            end
          end
        end

        ST_COMMIT: begin
          active_r  <= shadow_r;
          done_r    <= 1'b1;
          fab_rst_r <= 1'b1;
          ready_r   <= 1'b1;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end

        ST_DRAIN: begin
          if (accept_s) begin
            rem_r <= rem_r - 5'd1;
            if (rem_r == 5'd1) begin
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end
          end
        end

        default: begin
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clb_cfg_loader.sv
// tb_clb_cfg_loader: self-checking bench for clb_cfg_loader (NUM_CLB=4).
// Directed reset/commit-timing sequences, a table of frames with hand-computed
// results, a reset-mid-frame sequence, then random frames checked against a
// frame-level reference model.
module tb_clb_cfg_loader;
  import clb_cfg_pkg::*;

  localparam int NC = 4;
  localparam int CW = NC * CFG_W;

  typedef struct packed {
    logic [3:0]       n;
    logic [7:0][15:0] w;
    logic [CW-1:0]    cfg;
    logic [1:0]       err;
  } vec_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [15:0]   word_i = 16'h0000;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [CW-1:0] cfg_o;
  logic          fabric_rst_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [1:0]    err_code_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0]      frm[$];
  vec_t             tbl[$];
  logic [CFG_W-1:0] m_cfg [NC];
  logic [1:0]       m_err;

  clb_cfg_loader #(.NUM_CLB(NC)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .word_i       (word_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .cfg_o        (cfg_o),
    .fabric_rst_o (fabric_rst_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .err_code_o   (err_code_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] pk(input logic [12:0] c3, input logic [12:0] c2,
                                       input logic [12:0] c1, input logic [12:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [CW-1:0] m_pack();
    logic [CW-1:0] r;
    for (int i = 0; i < NC; i++) r[i*CFG_W +: CFG_W] = m_cfg[i];
    return r;
  endfunction

  // Frame-level reference: decide the outcome of a whole frame from its words.
  task automatic model_frame();
    logic [15:0] hdr, x, t;
    int s, n;
    hdr = frm[0];
    if (hdr[15:12] != 4'hA) begin
      m_err = 2'b01;
      return;
    end
    s = int'(hdr[11:8]);
    n = int'(hdr[7:4]) + 1;
    if (s + n > NC) begin
      m_err = 2'b10;
      return;
    end
    x = 16'h0000;
    for (int i = 0; i <= n; i++) x = x ^ frm[i];
    if (frm[n+1] != x) begin
      m_err = 2'b11;
      return;
    end
    for (int i = 0; i < n; i++) begin
      t = frm[1+i];
      m_cfg[s+i] = t[12:0];
    end
    m_err = 2'b00;
  endtask

  // Called at a negedge; returns at the negedge after the word transferred.
  task automatic send_word(input logic [15:0] w);
    int waited;
    waited  = 0;
    word_i  = w;
    valid_i = 1'b1;
    while (ready_o !== 1'b1 && waited < 20) begin
      @(negedge clk_i);
      waited++;
    end
    if (ready_o !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: ready_o=%b after %0d cycles, expected 1", ready_o, waited);
    end
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic send_frame(input bit bubbles);
    foreach (frm[i]) begin
      if (bubbles) repeat ($urandom_range(0, 2)) @(negedge clk_i);
      send_word(frm[i]);
    end
  endtask

  // Let any commit complete, then compare the settled outputs.
  task automatic check_frame(input string tag, input logic [CW-1:0] exp_cfg, input logic [1:0] exp_err);
    repeat (2) @(negedge clk_i);
    check({tag, "_cfg"},  64'(cfg_o), 64'(exp_cfg));
    check({tag, "_code"}, 64'(err_code_o), 64'(exp_err));
    check({tag, "_err"},  64'(err_o), 64'(exp_err != 2'b00));
    check({tag, "_busy"}, 64'(busy_o), 64'(0));
  endtask

  task automatic add_vec(input logic [CW-1:0] c, input logic [1:0] e);
    vec_t v;
    v     = '0;
    v.n   = 4'(frm.size());
    foreach (frm[i]) v.w[i] = frm[i];
    v.cfg = c;
    v.err = e;
    tbl.push_back(v);
  endtask

  initial begin
    int kind, s, n, lo;
    logic [15:0] hdr, x, d;
    vec_t cur;

    // Frame table; rows run in order, each starting from the previous row's state.
    frm = '{16'hA010, 16'h0491, 16'h1102, 16'hB583};
    add_vec(pk(13'h0, 13'h0, 13'h1102, 13'h0491), 2'b00);
    frm = '{16'hA010, 16'h0491, 16'h1102, 16'h0000};
    add_vec(pk(13'h0, 13'h0, 13'h1102, 13'h0491), 2'b11);
    frm = '{16'hA010, 16'h0111, 16'h0222, 16'h0000};
    add_vec(pk(13'h0, 13'h0, 13'h1102, 13'h0491), 2'b11);
    frm = '{16'hA200, 16'h0333, 16'hA133};
    add_vec(pk(13'h0, 13'h0333, 13'h1102, 13'h0491), 2'b00);
    frm = '{16'hA230, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
    add_vec(pk(13'h0, 13'h0333, 13'h1102, 13'h0491), 2'b10);
    frm = '{16'hA000, 16'h0007, 16'hA007};
    add_vec(pk(13'h0, 13'h0333, 13'h1102, 13'h0007), 2'b00);
    frm = '{16'h5010};
    add_vec(pk(13'h0, 13'h0333, 13'h1102, 13'h0007), 2'b01);
    frm = '{16'hA000, 16'hFFFF, 16'h5FFF};
    add_vec(pk(13'h0, 13'h0333, 13'h1102, 13'h1FFF), 2'b00);
    frm = '{16'hA300, 16'h0AAA, 16'hA9AA};
    add_vec(pk(13'h0AAA, 13'h0333, 13'h1102, 13'h1FFF), 2'b00);
    frm = '{16'hA310, 16'h0000, 16'h0000, 16'h0000};
    add_vec(pk(13'h0AAA, 13'h0333, 13'h1102, 13'h1FFF), 2'b10);
    frm = '{16'hA03C, 16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'hA033};
    add_vec(pk(13'h0008, 13'h0004, 13'h0002, 13'h0001), 2'b00);
    frm = '{16'hA000, 16'h0123, 16'h0000};
    add_vec(pk(13'h0008, 13'h0004, 13'h0002, 13'h0001), 2'b11);
    frm = '{16'hA100, 16'h1555, 16'hB455};
    add_vec(pk(13'h0008, 13'h0004, 13'h1555, 13'h0001), 2'b00);

    // Reset state.
    repeat (3) @(negedge clk_i);
    check("rst_cfg",   64'(cfg_o), 64'(0));
    check("rst_fab",   64'(fabric_rst_o), 64'(1));
    check("rst_busy",  64'(busy_o), 64'(0));
    check("rst_ready", 64'(ready_o), 64'(0));
    check("rst_done",  64'(done_o), 64'(0));
    check("rst_err",   64'({err_o, err_code_o}), 64'(0));
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rel_ready", 64'(ready_o), 64'(1));
    check("rel_fab",   64'(fabric_rst_o), 64'(1));

    // First good frame with commit timing, plus a header held valid during COMMIT.
    send_word(16'hA010);
    send_word(16'h0491);
    send_word(16'h1102);
    send_word(16'hB583);
    check("commit_ready", 64'(ready_o), 64'(0));
    check("commit_fab",   64'(fabric_rst_o), 64'(1));
    check("commit_busy",  64'(busy_o), 64'(1));
    check("commit_done",  64'(done_o), 64'(0));
    check("commit_cfg",   64'(cfg_o), 64'(0));
    word_i  = 16'hA000;
    valid_i = 1'b1;
    @(negedge clk_i);
    check("done_pulse", 64'(done_o), 64'(1));
    check("done_cfg",   64'(cfg_o), 64'(pk(13'h0, 13'h0, 13'h1102, 13'h0491)));
    check("done_fab",   64'(fabric_rst_o), 64'(1));
    check("held_hdr_not_taken", 64'(busy_o), 64'(0));
    check("done_ready", 64'(ready_o), 64'(1));
    @(negedge clk_i);
    valid_i = 1'b0;
    check("done_width",     64'(done_o), 64'(0));
    check("fab_fall",       64'(fabric_rst_o), 64'(0));
    check("held_hdr_taken", 64'(busy_o), 64'(1));
    send_word(16'h0007);
    send_word(16'hA007);
    check_frame("held_frame", pk(13'h0, 13'h0, 13'h1102, 13'h0007), 2'b00);

    // Table-driven frames.
    for (int v = 0; v < tbl.size(); v++) begin
      cur = tbl[v];
      for (int i = 0; i < int'(cur.n); i++) send_word(cur.w[i]);
      check_frame($sformatf("vec%0d", v), cur.cfg, cur.err);
    end

    // Reset in the middle of a frame.
    send_word(16'hA010);
    send_word(16'h0491);
    check("mid_busy", 64'(busy_o), 64'(1));
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midrst_cfg",   64'(cfg_o), 64'(0));
    check("midrst_busy",  64'(busy_o), 64'(0));
    check("midrst_fab",   64'(fabric_rst_o), 64'(1));
    check("midrst_ready", 64'(ready_o), 64'(0));
    rst_i = 1'b0;
    @(negedge clk_i);
    check("midrel_ready", 64'(ready_o), 64'(1));
    for (int i = 0; i < NC; i++) m_cfg[i] = '0;
    m_err = 2'b00;
    // The leftover data word now lands in IDLE and is parsed as a header.
    frm = '{16'h1102};
    model_frame();
    send_frame(1'b0);
    check_frame("after_rst", m_pack(), m_err);

    // Random frames against the reference model.
    for (int f = 0; f < 40; f++) begin
      kind = int'($urandom_range(0, 3));
      frm.delete();
      case (kind)
        0, 1: begin
          s   = int'($urandom_range(0, NC - 1));
          n   = int'($urandom_range(1, NC - s));
          hdr = {4'hA, 4'(s), 4'(n - 1), 4'($urandom)};
          frm.push_back(hdr);
          x = hdr;
          for (int i = 0; i < n; i++) begin
            d = 16'(($urandom_range(0, 3) << MODE_LSB) | ($urandom_range(0, 7) << SELA_LSB) |
                    ($urandom_range(0, 7) << SELB_LSB) | ($urandom_range(0, 15) << ROUTE_LSB) |
                    ($urandom_range(0, 1) << FFEN_BIT) | ($urandom_range(0, 7) << 13));
            frm.push_back(d);
            x = x ^ d;
          end
          if (kind == 1) x = x ^ 16'($urandom_range(1, 65535));
          frm.push_back(x);
        end
        2: begin
          hdr = 16'($urandom);
          if (hdr[15:12] == 4'hA) hdr[15:12] = 4'h5;
          frm.push_back(hdr);
        end
        default: begin
          s   = int'($urandom_range(0, 15));
          lo  = (s >= NC) ? 1 : NC + 1 - s;
          n   = int'($urandom_range(lo, 16));
          hdr = {4'hA, 4'(s), 4'(n - 1), 4'($urandom)};
          frm.push_back(hdr);
          for (int i = 0; i <= n; i++) frm.push_back(16'($urandom));
        end
      endcase
      model_frame();
      send_frame(1'b1);
      check_frame($sformatf("rnd%0d_k%0d", f, kind), m_pack(), m_err);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
